// File: rtl/fp32_to_fixed.sv
// IEEE-754 single to signed fixed-point (FRAC_BITS fractional bits), one shift per cycle.
// Special inputs (NaN/Inf/zero/overflow) resolve at capture; normal words shift, round half away from zero, then sign.
module fp32_to_fixed #(
  parameter int XLEN      = 32,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overflow,
  output logic             invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
  localparam logic signed [9:0] S_OFF   = 10'(FRAC_BITS - 150);
  localparam logic signed [9:0] TOP_LIM = 10'(OUT_W - 1);

  state_t r_state, w_state_nxt;

  logic             r_sign;
  logic             r_left;
  logic [4:0]       r_cnt;
  logic [OUT_W-1:0] r_mag;
  logic             r_guard;
  logic             r_sticky;
  logic [OUT_W-1:0] r_out_data;
  logic             r_ovf;
  logic             r_inv;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic [23:0]        w_mant;
  logic signed [9:0]  w_s;
  logic signed [9:0]  w_top;
  logic [9:0]         w_abs;
  logic [4:0]         w_k;
  logic               w_nan;
  logic               w_inf;
  logic               w_zero;
  logic               w_big;
  logic               w_exact_min;
  logic               w_special;
  logic [OUT_W-1:0]   w_sat;
  logic [OUT_W:0]     w_rnd;
  logic               w_round_ovf;
  logic [OUT_W-1:0]   w_neg;

  assign w_sign  = in_data[31];
  assign w_exp   = in_data[30:23];
  assign w_frac  = in_data[22:0];
  assign w_mant  = {1'b1, w_frac};
  assign w_s     = $signed({2'b00, w_exp}) + S_OFF;
  assign w_top   = w_s + 10'sd23;
  assign w_abs   = w_s[9] ? 10'(-w_s) : 10'(w_s);
  assign w_k     = (w_abs > 10'd25) ? 5'd25 : w_abs[4:0];

  assign w_nan       = (w_exp == 8'hFF) && (w_frac != 23'd0);
  assign w_inf       = (w_exp == 8'hFF) && (w_frac == 23'd0);
  assign w_zero      = (w_exp == 8'h00);
  assign w_big       = (w_top >= TOP_LIM);
  // -2^(OUT_W-1) is representable even though its magnitude hits the overflow boundary
  assign w_exact_min = w_sign && (w_frac == 23'd0) && (w_top == TOP_LIM);
  assign w_special   = w_nan || w_inf || w_zero || w_big;
  assign w_sat       = w_sign ? SAT_MIN : SAT_MAX;

  assign w_rnd       = {1'b0, r_mag} + {{OUT_W{1'b0}}, r_guard};
  assign w_round_ovf = |w_rnd[OUT_W:OUT_W-1];
  assign w_neg       = ~w_rnd[OUT_W-1:0] + ONE;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;
  assign overflow  = r_ovf;
  assign invalid   = r_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_special)       w_state_nxt = DONE;
          else if (w_k == 5'd0) w_state_nxt = ROUND;
          else                 w_state_nxt = SHIFT;
        end
      end
      SHIFT: if (r_cnt == 5'd1) w_state_nxt = ROUND;
      ROUND: w_state_nxt = DONE;
      DONE:  if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_left     <= 1'b0;
      r_cnt      <= 5'd0;
      r_mag      <= '0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign   <= w_sign;
            r_left   <= ~w_s[9];
            r_cnt    <= w_k;
            r_mag    <= {{(OUT_W-24){1'b0}}, w_mant};
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            if (w_nan) begin
              r_out_data <= '0;
              r_inv      <= 1'b1;
            end else if (w_inf) begin
              r_out_data <= w_sat;
              r_ovf      <= 1'b1;
            end else if (w_zero) begin
              r_out_data <= '0;
            end else if (w_exact_min) begin
              r_out_data <= SAT_MIN;
            end else if (w_big) begin
              r_out_data <= w_sat;
              r_ovf      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        ROUND: begin
          if (w_round_ovf) begin
            r_out_data <= r_sign ? SAT_MIN : SAT_MAX;
            r_ovf      <= 1'b1;
          end else begin
            r_out_data <= r_sign ? w_neg : w_rnd[OUT_W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_data <= '0;
            r_ovf      <= 1'b0;
            r_inv      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Directed-vector bench for fp32_to_fixed (OUT_W=32, FRAC_BITS=16).
module tb_fp32_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overflow;
  logic        invalid;

  int checks   = 0;
  int failures = 0;
  int lat;

  fp32_to_fixed #(.XLEN(32), .OUT_W(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents din for one cycle after an edge; lat counts edges until out_valid is seen.
  task automatic send(input string tag, input logic [31:0] din, output int n);
    @(posedge clk);
    #1;
    in_data  = din;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      #1;
      in_valid = 1'b0;
      if (out_valid) break;
      if (n > 60) break;
    end
  endtask

  task automatic expect_res(input string tag, input int n, input int exp_lat,
                            input logic [31:0] exp_d, input logic exp_o, input logic exp_i);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_flags"}, {30'd0, overflow, invalid}, {30'd0, exp_o, exp_i});
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ack_state"}, {29'd0, out_valid, in_ready, overflow | invalid}, 32'h2);
    chk({tag, "_ack_data"}, out_data, 32'h0);
  endtask

  task automatic convert(input string tag, input logic [31:0] din, input int exp_lat,
                         input logic [31:0] exp_d, input logic exp_o, input logic exp_i);
    int n;
    send(tag, din, n);
    expect_res(tag, n, exp_lat, exp_d, exp_o, exp_i);
    ack(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #1;
    chk("reset_outputs", {29'd0, in_ready, out_valid, overflow | invalid}, 32'h4);
    chk("reset_data", out_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    convert("one",      32'h3F800000, 9,  32'h00010000, 1'b0, 1'b0);
    convert("neg2p5",   32'hC0200000, 8,  32'hFFFD8000, 1'b0, 1'b0);
    convert("half_lsb", 32'h37000000, 26, 32'h00000001, 1'b0, 1'b0);
    convert("qtr_lsb",  32'h36800000, 27, 32'h00000000, 1'b0, 1'b0);
    convert("max_norm", 32'h46FFFE00, 9,  32'h7FFF0000, 1'b0, 1'b0);
    convert("big",      32'h471C4000, 1,  32'h7FFFFFFF, 1'b1, 1'b0);
    convert("exact_min",32'hC7000000, 1,  32'h80000000, 1'b0, 1'b0);
    convert("below_min",32'hC7000001, 1,  32'h80000000, 1'b1, 1'b0);
    convert("pos_inf",  32'h7F800000, 1,  32'h7FFFFFFF, 1'b1, 1'b0);
    convert("neg_inf",  32'hFF800000, 1,  32'h80000000, 1'b1, 1'b0);
    convert("nan",      32'h7FC00000, 1,  32'h00000000, 1'b0, 1'b1);
    convert("denormal", 32'h00400000, 1,  32'h00000000, 1'b0, 1'b0);
    convert("neg_zero", 32'h80000000, 1,  32'h00000000, 1'b0, 1'b0);

    // Backpressure: result held while a competing input is offered
    send("bp_first", 32'hC0200000, lat);
    expect_res("bp_first", lat, 8, 32'hFFFD8000, 1'b0, 1'b0);
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", out_data, 32'hFFFD8000);
      chk("bp_hold_ctl", {29'd0, out_valid, in_ready, overflow | invalid}, 32'h4);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'h1);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'b0;
      if (out_valid || lat > 60) break;
    end
    expect_res("bp_second", lat, 9, 32'h00010000, 1'b0, 1'b0);
    ack("bp_second");

    // Asynchronous reset in the middle of a shift sequence
    @(posedge clk);
    #1;
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_shift_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {29'd0, in_ready, out_valid, overflow | invalid}, 32'h4);
    chk("mid_rst_data", out_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    convert("after_rst", 32'h40000000, 8, 32'h00020000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_to_fixed.md
Name: fp32_to_fixed

Overview:
- Converts IEEE-754 single-precision words into signed two's-complement fixed-point (Q format set by FRAC_BITS). Typical sources are the floating-point adder results and the float-domain battery computations.
- Sits on the consumer side of the float datapath. It feeds fixed-point consumers such as the PWM, threshold comparators and telemetry registers.
- Iterative: one mantissa bit shifts per cycle. Uses a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, input float width (only 32 supported).
- OUT_W, 32, output fixed-point width in bits (min 26).
- FRAC_BITS, 16, number of fractional bits in the output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_data holds a float to convert
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  XLEN  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_valid  output  1  out_data and flags are valid
- out_ready  input  1  downstream accepts the result
- out_data  output  OUT_W  signed fixed-point result, FRAC_BITS fractional bits
- overflow  output  1  result saturated; valid with out_valid
- invalid  output  1  input was NaN; valid with out_valid

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_data=0, overflow=0, invalid=0. All internal registers cleared; any in-flight conversion is discarded.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch sign, exp and mant={1,frac}, and compute s = exp - 150 + FRAC_BITS (signed, 10 bits).
- Classification at capture (first match wins; each goes IDLE->DONE next cycle):
  - exp==255 && frac!=0 (NaN): result 0, invalid=1.
  - exp==255 && frac==0 (Inf): saturate, overflow=1.
  - exp==0 (zero or denormal, flushed): result 0, no flags.
  - 23+s >= OUT_W-1: saturate, overflow=1. Exception: sign=1 with mant==0x800000 and 23+s==OUT_W-1 gives exactly -2^(OUT_W-1) with overflow=0.
- Normal path: k = |s| capped at 25. If k==0, go to ROUND; else go to SHIFT with counter=k.
- SHIFT: each cycle shift the magnitude by 1 bit and decrement counter; exit to ROUND when counter reaches 1->0.
  - s>0: shift left.
  - s<0: shift right. Bit shifted out goes to guard; old guard ORs into sticky.
- ROUND: round-to-nearest, ties away from zero: mag += guard. If mag >= 2^(OUT_W-1), saturate with overflow=1. Otherwise apply sign (two's-complement negate when sign=1). Next state DONE.
- Saturation values: +max = 2^(OUT_W-1)-1; -min = -2^(OUT_W-1).
- DONE: out_valid=1. out_data and flags stay stable while out_ready=0. On out_ready=1, go to IDLE; out_valid drops next cycle and flags clear.
- Latency: handshake at edge N gives out_valid=1 after edge N+k+2 (normal path) or N+1 (special cases).
- Throughput: one conversion in flight. in_ready=0 in SHIFT/ROUND/DONE, so a new word is accepted at earliest the cycle after the out handshake.
- Working magnitude register is OUT_W bits, plus guard and sticky; no intermediate wrap is possible given the capture overflow check.
- out_ready is ignored outside DONE; in_data/in_valid are ignored outside IDLE.

Test Plan:
- 0x3F800000 (1.0), OUT_W=32, FRAC_BITS=16 -> out_data=0x00010000, flags 0; out_valid 9 cycles after accept (k=7).
- 0xC0200000 (-2.5) -> 0xFFFD8000. 0x37000000 (2^-17, half LSB) -> 0x00000001 (tie away). 0x36800000 (2^-18) -> 0x00000000.
- 0x471C4000 (40000.0) -> 0x7FFFFFFF, overflow=1. 0xC7000000 (-32768.0) -> 0x80000000, overflow=0. 0x7F800000 (+Inf) -> 0x7FFFFFFF, overflow=1. All three have latency 1.
- 0x7FC00000 (NaN) -> 0x00000000, invalid=1. 0x00400000 (denormal) and 0x80000000 (-0) -> 0x00000000, flags 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/flags stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> IDLE next cycle; next word accepted; results match order.
- Assert rst for 1 cycle during SHIFT of 1.0 -> outputs return to reset values immediately, in_ready=1. A following 0x40000000 (2.0) converts to 0x00020000 cleanly.
